ultrasonic_ranger: RTL

Drives the front and rear ultrasonic sensors and converts echo pulse widths into the 8-bit meter distances consumed by the collision detection logic (distance_front/distance_rear). The two sensors are fired alternately, front then rear, so their pings cannot cross-talk. Each measurement publishes a saturated distance with a one-cycle valid strobe. A sensor that never echoes reports the maximum (safe) distance and sets a fault flag.

---
 rtl/ultrasonic_ranger_pkg.sv | 23 ++
 rtl/ultrasonic_ranger_echo_sync.sv | 21 ++
 rtl/ultrasonic_ranger.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types and constants for the front/rear ultrasonic ranger.
package ranger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        GAP
    } state_t;

    localparam logic SEL_FRONT = 1'b0;
    localparam logic SEL_REAR  = 1'b1;

    localparam int              DIST_W   = 8;
    localparam logic [DIST_W-1:0] DIST_MAX = 8'hFF;

    // Width of a counter that runs 0 .. p-1 (at least one bit).
    function automatic int cnt_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Two-flop synchronizer for an asynchronous sensor echo line.
module echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Alternating front/rear ultrasonic ranging: trigger, time the echo, publish
// a saturated meter distance with a one-cycle valid strobe.
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int TRIG_CYCLES      = 500,
    parameter int CYCLES_PER_METER = 291545,
    parameter int ECHO_WAIT_MAX    = 1500000,
    parameter int GAP_CYCLES       = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              echo_front,
    input  logic              echo_rear,
    output logic              trig_front,
    output logic              trig_rear,
    output logic [DIST_W-1:0] distance_front,
    output logic [DIST_W-1:0] distance_rear,
    output logic              front_valid,
    output logic              rear_valid,
    output logic [1:0]        sensor_fault
);

    localparam int TRIG_W = cnt_width(TRIG_CYCLES);
    localparam int SUB_W  = cnt_width(CYCLES_PER_METER);
    localparam int WAIT_W = cnt_width(ECHO_WAIT_MAX);
    localparam int GAP_W  = cnt_width(GAP_CYCLES);

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_METER - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ECHO_WAIT_MAX - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    // The first high cycle is seen in WAIT_ECHO; preload the counters with it.
    localparam logic [SUB_W-1:0]  FIRST_SUB = (CYCLES_PER_METER > 1) ? SUB_W'(1) : '0;
    localparam logic [DIST_W-1:0] FIRST_M   = (CYCLES_PER_METER > 1) ? 8'd0 : 8'd1;
    localparam logic [DIST_W-1:0] METER_SAT = DIST_MAX - 8'd1;

    state_t            state;
    logic              sel;
    logic [TRIG_W-1:0] trig_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DIST_W-1:0] meters;

    logic              echo_front_s;
    logic              echo_rear_s;
    logic              echo_s;

    logic              pub_en;
    logic              pub_timeout;
    logic [DIST_W-1:0] pub_dist;

    echo_sync u_sync_front (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (echo_front),
        .sync_out (echo_front_s)
    );

    echo_sync u_sync_rear (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (echo_rear),
        .sync_out (echo_rear_s)
    );

    assign echo_s = (sel == SEL_REAR) ? echo_rear_s : echo_front_s;

    // Publish decision: echo fell, meter count saturated, or the echo never came.
    always_comb begin
        pub_en      = 1'b0;
        pub_timeout = 1'b0;
        pub_dist    = DIST_MAX;
        case (state)
            WAIT_ECHO: begin
                if (!echo_s && wait_cnt == WAIT_LAST) begin
                    pub_en      = 1'b1;
                    pub_timeout = 1'b1;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    pub_en   = 1'b1;
                    pub_dist = meters;
                end else if (sub_cnt == SUB_LAST && meters == METER_SAT) begin
                    pub_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            sel            <= SEL_FRONT;
            trig_cnt       <= '0;
            wait_cnt       <= '0;
            sub_cnt        <= '0;
            gap_cnt        <= '0;
            meters         <= '0;
            trig_front     <= 1'b0;
            trig_rear      <= 1'b0;
            distance_front <= DIST_MAX;
            distance_rear  <= DIST_MAX;
            front_valid    <= 1'b0;
            rear_valid     <= 1'b0;
            sensor_fault   <= 2'b00;
        end else begin
            front_valid <= 1'b0;
            rear_valid  <= 1'b0;

            if (pub_en) begin
                if (sel == SEL_FRONT) begin
                    distance_front  <= pub_dist;
                    front_valid     <= 1'b1;
                    sensor_fault[0] <= pub_timeout;
                end else begin
                    distance_rear   <= pub_dist;
                    rear_valid      <= 1'b1;
                    sensor_fault[1] <= pub_timeout;
                end
                gap_cnt <= '0;
                state   <= GAP;
            end else begin
                case (state)
                    IDLE: begin
                        sel <= SEL_FRONT;
                        if (enable) begin
                            trig_cnt   <= '0;
                            trig_front <= 1'b1;
                            state      <= TRIG;
                        end
                    end
                    TRIG: begin
                        if (trig_cnt == TRIG_LAST) begin
                            trig_front <= 1'b0;
                            trig_rear  <= 1'b0;
                            wait_cnt   <= '0;
                            state      <= WAIT_ECHO;
                        end else begin
                            trig_cnt <= trig_cnt + 1'b1;
                        end
                    end
                    WAIT_ECHO: begin
                        if (echo_s) begin
                            sub_cnt <= FIRST_SUB;
                            meters  <= FIRST_M;
                            state   <= MEASURE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (sub_cnt == SUB_LAST) begin
                            sub_cnt <= '0;
                            meters  <= meters + 1'b1;
                        end else begin
                            sub_cnt <= sub_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            sel <= ~sel;
                            // A rear measurement closes the cycle; IDLE restarts with front.
                            if (sel == SEL_REAR || !enable) begin
                                state <= IDLE;
                            end else begin
                                trig_cnt  <= '0;
                                trig_rear <= 1'b1;
                                state     <= TRIG;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
